// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_pkg
//  Description : Shared size encodings and store-buffer entry layout for the
//                data-memory store buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_pkg;

   // Store/load size encoding, identical to DM DMin_Src
   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   // One queued store
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic [31:0] pc;
   } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fifo
//  Description : DEPTH-entry register-array FIFO of store entries. Exposes
//                every entry address and its valid bit so the parent can
//                search for word-address conflicts.
//  Revision    : 1.0  initial release
// ============================================================================
module sb_fifo
   import dm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  sb_entry_t                     push_entry,
   input  logic                          pop,
   output sb_entry_t                     head_entry,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH-1:0][31:0]        entry_addr,
   output logic [DEPTH-1:0]              entry_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
   localparam logic [AW:0]   C_CNT_ONE = (AW + 1)'(1);

   sb_entry_t        r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [AW:0]      r_count;
   logic [DEPTH-1:0] r_valid;

   // Payload storage; contents are don't-care until the valid bit is set
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_tail] <= push_entry;
      end
   end

   // Pointers, occupancy and per-entry valid bits; pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + C_PTR_ONE;
         end
         if (pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + C_PTR_ONE;
         end
         if (push && !pop) begin
            r_count <= r_count + C_CNT_ONE;
         end else if (pop && !push) begin
            r_count <= r_count - C_CNT_ONE;
         end
      end
   end

   assign head_entry  = r_mem[r_head];
   assign count       = r_count;
   assign entry_valid = r_valid;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_addr
         assign entry_addr[i] = r_mem[i].addr;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_buffer
//  Description : Store buffer between the M-stage register and DM. Queues
//                stores, drains them through DM's single port when no load
//                needs it, and stalls loads that hit a pending store word.
//                Optional macro DM_STBUF_BYPASS_EN: a store arriving with the
//                FIFO empty and no load present writes DM directly.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_store_buffer
   import dm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    st_valid,
   input  logic [31:0]             st_addr,
   input  logic [31:0]             st_data,
   input  logic [1:0]              st_size,
   input  logic [31:0]             st_pc,
   output logic                    st_ready,
   input  logic                    ld_valid,
   input  logic [31:0]             ld_addr,
   output logic                    ld_stall,
   output logic [31:0]             dm_addr,
   output logic [31:0]             dm_wd,
   output logic                    dm_we,
   output logic [31:0]             dm_pc,
   output logic [31:0]             dm_src,
   output logic [$clog2(DEPTH):0]  sb_count,
   output logic                    sb_empty
);

   localparam logic [$clog2(DEPTH):0] C_FULL = ($clog2(DEPTH) + 1)'(DEPTH);

   sb_entry_t              w_head;
   sb_entry_t              w_push_entry;
   logic [DEPTH-1:0][31:0] w_entry_addr;
   logic [DEPTH-1:0]       w_entry_valid;
   logic                   w_conflict;
   logic                   w_load_grant;
   logic                   w_bypass;
   logic                   w_push;
   logic                   w_pop;

   assign w_push_entry = '{addr: st_addr, data: st_data, size: st_size, pc: st_pc};

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (w_push),
      .push_entry  (w_push_entry),
      .pop         (w_pop),
      .head_entry  (w_head),
      .count       (sb_count),
      .entry_addr  (w_entry_addr),
      .entry_valid (w_entry_valid)
   );

   assign sb_empty = (sb_count == '0);
   assign st_ready = (sb_count != C_FULL);

   // Word-granular search of already-queued stores; size ignored on purpose
   always_comb begin
      w_conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_entry_valid[i] && (w_entry_addr[i][31:2] == ld_addr[31:2])) begin
            w_conflict = 1'b1;
         end
      end
      w_conflict = w_conflict && ld_valid;
   end

   assign ld_stall     = w_conflict;
   assign w_load_grant = ld_valid && !w_conflict;

`ifdef DM_STBUF_BYPASS_EN
   assign w_bypass = st_valid && sb_empty && !ld_valid;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = st_valid && st_ready && !w_bypass;
   // A conflicting load does not block the drain, so stalls always resolve
   assign w_pop  = !w_load_grant && !sb_empty && !reset;

   // DM port mux: granted load, then FIFO head, then direct store, else idle
   always_comb begin
      dm_addr = ld_addr;
      dm_wd   = '0;
      dm_we   = 1'b0;
      dm_pc   = '0;
      dm_src  = '0;
      if (w_load_grant) begin
         dm_addr = ld_addr;
      end else if (!sb_empty) begin
         dm_addr = w_head.addr;
         dm_wd   = w_head.data;
         dm_pc   = w_head.pc;
         dm_src  = {30'd0, w_head.size};
         dm_we   = !reset;
      end else if (w_bypass) begin
         dm_addr = st_addr;
         dm_wd   = st_data;
         dm_pc   = st_pc;
         dm_src  = {30'd0, st_size};
         dm_we   = !reset;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_store_buffer
//  Description : Directed self-checking bench for dm_store_buffer (DEPTH=4,
//                default build without the direct-write path).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_size;
   logic [31:0] st_pc;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_stall;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic        dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_src;
   logic [2:0]  sb_count;
   logic        sb_empty;

   int errors = 0;
   int checks = 0;

   dm_store_buffer #(.DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .st_valid (st_valid),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_size  (st_size),
      .st_pc    (st_pc),
      .st_ready (st_ready),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_stall (ld_stall),
      .dm_addr  (dm_addr),
      .dm_wd    (dm_wd),
      .dm_we    (dm_we),
      .dm_pc    (dm_pc),
      .dm_src   (dm_src),
      .sb_count (sb_count),
      .sb_empty (sb_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; checks follow 1ns later
   task automatic next;
      @(negedge clk);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_valid = 1'b1; st_addr = a; st_data = d; st_size = s; st_pc = 32'h1000 + a;
   endtask

   task automatic no_store;
      st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; st_pc = '0;
   endtask

   initial begin
      reset = 1'b1; no_store(); ld_valid = 1'b0; ld_addr = '0;
      next(); next();
      reset = 1'b0;
      #1;
      // Reset state
      check("rst_empty",  32'(sb_empty), 32'd1);
      check("rst_ready",  32'(st_ready), 32'd1);
      check("rst_we",     32'(dm_we),    32'd0);
      check("rst_stall",  32'(ld_stall), 32'd0);
      check("rst_count",  32'(sb_count), 32'd0);

      // sw 0xDEADBEEF -> 0x10: queued, written the following cycle
      store(32'h10, 32'hDEADBEEF, 2'd0);
      #1 check("sw_we_same_cycle", 32'(dm_we), 32'd0);
      next(); no_store(); #1;
      check("sw_we",   32'(dm_we), 32'd1);
      check("sw_addr", dm_addr,    32'h10);
      check("sw_wd",   dm_wd,      32'hDEADBEEF);
      check("sw_src",  dm_src,     32'd0);
      check("sw_pc",   dm_pc,      32'h1010);
      next(); #1;
      check("sw_drained", 32'(sb_empty), 32'd1);

      // sb 0xAB -> 0x23, then lw 0x20 conflicts for one cycle
      store(32'h23, 32'h000000AB, 2'd2);
      next(); no_store(); ld_valid = 1'b1; ld_addr = 32'h20; #1;
      check("sb_stall",   32'(ld_stall), 32'd1);
      check("sb_we",      32'(dm_we),    32'd1);
      check("sb_addr",    dm_addr,       32'h23);
      check("sb_wd",      dm_wd,         32'hAB);
      check("sb_src",     dm_src,        32'd2);
      next(); #1;
      check("lw_stall",   32'(ld_stall), 32'd0);
      check("lw_addr",    dm_addr,       32'h20);
      check("lw_we",      32'(dm_we),    32'd0);

      // Fill with load held on 0x100, then drain in order
      ld_addr = 32'h100;
      for (int k = 0; k < 4; k++) begin
         store(32'(4 * k), 32'h5000 + 32'(k), 2'd0);
         #1 check("fill_ready", 32'(st_ready), 32'd1);
         check("fill_we", 32'(dm_we), 32'd0);
         next();
      end
      store(32'h10, 32'h5555, 2'd0); #1;
      check("full_count", 32'(sb_count), 32'd4);
      check("full_ready", 32'(st_ready), 32'd0);
      check("full_ld_addr", dm_addr, 32'h100);
      check("full_stall", 32'(ld_stall), 32'd0);
      no_store(); ld_valid = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
         check("drain_we",   32'(dm_we), 32'd1);
         check("drain_addr", dm_addr,    32'(4 * k));
         check("drain_wd",   dm_wd,      32'h5000 + 32'(k));
         next(); #1;
      end
      check("drain_empty", 32'(sb_empty), 32'd1);

      // sh 0x1234 -> 0x42, then lh 0x40 (same word) must stall
      store(32'h42, 32'h1234, 2'd1);
      next(); no_store(); ld_valid = 1'b1; ld_addr = 32'h40; #1;
      check("sh_stall", 32'(ld_stall), 32'd1);
      check("sh_addr",  dm_addr,       32'h42);
      check("sh_src",   dm_src,        32'd1);
      check("sh_wd",    dm_wd,         32'h1234);
      next(); #1;
      check("lh_stall", 32'(ld_stall), 32'd0);
      check("lh_addr",  dm_addr,       32'h40);

      // Three pending stores, then reset while the drain would proceed
      ld_addr = 32'h100;
      for (int k = 0; k < 3; k++) begin
         store(32'h300 + 32'(4 * k), 32'hA0 + 32'(k), 2'd0);
         next();
      end
      no_store(); #1;
      check("pre_rst_count", 32'(sb_count), 32'd3);
      ld_valid = 1'b0; reset = 1'b1; #1;
      check("rst_mid_we", 32'(dm_we), 32'd0);
      next(); reset = 1'b0; #1;
      check("rst_mid_empty", 32'(sb_empty), 32'd1);
      check("rst_mid_count", 32'(sb_count), 32'd0);
      for (int k = 0; k < 3; k++) begin
         check("rst_no_write", 32'(dm_we), 32'd0);
         next(); #1;
      end

      // Two queued, then push+pop every cycle across the pointer wrap
      ld_valid = 1'b1; ld_addr = 32'h100;
      for (int k = 0; k < 2; k++) begin
         store(32'h200 + 32'(4 * k), 32'hB0 + 32'(k), 2'd0);
         next();
      end
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         store(32'h200 + 32'(4 * (k + 2)), 32'hB0 + 32'(k + 2), 2'd0); #1;
         check("pp_count", 32'(sb_count), 32'd2);
         check("pp_addr",  dm_addr,       32'h200 + 32'(4 * k));
         check("pp_wd",    dm_wd,         32'hB0 + 32'(k));
         next();
      end
      no_store(); #1;
      check("pp_count_end", 32'(sb_count), 32'd2);
      for (int k = 4; k < 6; k++) begin
         check("pp_tail_addr", dm_addr, 32'h200 + 32'(4 * k));
         check("pp_tail_we",   32'(dm_we), 32'd1);
         next(); #1;
      end
      check("pp_empty", 32'(sb_empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
